counter_sequencer: RTL and testbench

//  Control block for the team's binary counter datapath: accepts start/stop/pause commands

---
 rtl/counter_pkg.sv | 8 +
 rtl/counter_core.sv | 15 +
 rtl/counter_sequencer.sv | 75 +++++++
 tb/tb_counter_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: command opcodes and sequencer state encoding shared by the counter sequencer.
package counter_pkg;
    localparam logic [1:0] OP_STOP     = 2'b00;
    localparam logic [1:0] OP_ONESHOT  = 2'b01;
    localparam logic [1:0] OP_PERIODIC = 2'b10;
    localparam logic [1:0] OP_PAUSE    = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
endpackage

// File: rtl/counter_core.sv
// counter_core: WIDTH-bit up-counter; clear wins over enable.
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= count + WIDTH'(1);
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven one-shot/periodic sequencer around counter_core
// with terminal-count pulse, done level and saturating wrap count.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_limit,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              tc_pulse,
    output logic [WRAP_W-1:0] wraps
);
    state_t            state, state_n;
    logic [WIDTH-1:0]  limit_r;
    logic              periodic, clr, en, load, term, acc, start;

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .count(count)
    );

    assign term      = state == RUN && count == limit_r;
    assign cmd_ready = !term;
    assign acc       = cmd_valid && cmd_ready;
    assign start     = cmd_op == OP_ONESHOT || cmd_op == OP_PERIODIC;
    assign busy      = state == RUN || state == PAUSE;
    assign done      = state == DONE;

    // Terminal cycle outranks commands; cmd_ready is low then so none can be accepted.
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        if (term) begin
            state_n = periodic ? RUN : DONE;
            clr     = periodic;
        end else if (acc && start) begin
            state_n = RUN;
            clr     = 1'b1;
            load    = 1'b1;
        end else if (acc && cmd_op == OP_STOP && state != IDLE) begin
            state_n = IDLE;
            clr     = 1'b1;
        end else if (acc && cmd_op == OP_PAUSE && busy) begin
            state_n = state == RUN ? PAUSE : RUN;
        end else begin
            en = state == RUN;
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= IDLE;
            limit_r  <= '0;
            periodic <= 1'b0;
            tc_pulse <= 1'b0;
            wraps    <= '0;
        end else begin
            state    <= state_n;
            tc_pulse <= term;
            if (load) begin
                limit_r  <= cmd_limit;
                periodic <= cmd_op == OP_PERIODIC;
            end
            wraps <= load ? '0 : (term && periodic && wraps != '1) ? wraps + WRAP_W'(1) : wraps;
        end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed stimulus queues expected per-cycle outputs; a negedge monitor pops and compares.
module tb_counter_sequencer;
  import counter_pkg::*;
  typedef struct {
    string       nm;
    logic [15:0] v;
  } exp_t;
  logic       clk = 1'b1;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = OP_STOP;
  logic [3:0] cmd_limit = '0;
  logic [3:0] count;
  logic       busy, done, tc_pulse;
  logic [7:0] wraps;
  exp_t exp_q[$];
  int   passed = 0;
  int   total = 0;
  counter_sequencer #(.WIDTH(4), .WRAP_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_limit(cmd_limit), .count(count), .busy(busy),
    .done(done), .tc_pulse(tc_pulse), .wraps(wraps)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    logic [15:0] act;
    exp_t        e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {count, busy, done, tc_pulse, cmd_ready, wraps};
      total++;
      if (act == e.v) passed++;
      else $display("FAIL %s t=%0t act count=%0d busy=%0b done=%0b tc=%0b ready=%0b wraps=%0d exp count=%0d busy=%0b done=%0b tc=%0b ready=%0b wraps=%0d",
                    e.nm, $time, act[15:12], act[11], act[10], act[9], act[8], act[7:0],
                    e.v[15:12], e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
    end
  end
  task automatic cyc(input logic rv, input logic v, input logic [1:0] op, input logic [3:0] lim,
                     input string nm, input logic [3:0] c, input logic b, input logic d,
                     input logic t, input logic r, input logic [7:0] w);
    @(posedge clk);
    #1;
    reset     = rv;
    cmd_valid = v;
    cmd_op    = op;
    cmd_limit = lim;
    exp_q.push_back('{nm, {c, b, d, t, r, w}});
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
  initial begin
    #11;
    exp_q.push_back('{"reset", {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0}});
    #4 reset = 1'b1;
    cyc(1, 1, OP_ONESHOT, 5, "os_start", 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, OP_STOP, 0, "os_run", 4'(k), 1, 0, 0, 1, 0);
    cyc(1, 1, OP_STOP, 0, "os_term", 5, 1, 0, 0, 0, 0);
    cyc(1, 0, OP_STOP, 0, "os_done", 5, 0, 1, 1, 1, 0);
    cyc(1, 0, OP_STOP, 0, "os_hold", 5, 0, 1, 0, 1, 0);
    cyc(1, 1, OP_PERIODIC, 3, "pe_start", 5, 0, 1, 0, 1, 0);
    for (int i = 0; i <= 12; i++)
      cyc(1, 0, OP_STOP, 0, "pe_run", 4'(i % 4), 1, 0, 1'(i > 0 && i % 4 == 0),
          1'(i % 4 != 3), 8'(i / 4));
    cyc(1, 1, OP_ONESHOT, 9, "ps_start", 1, 1, 0, 0, 1, 3);
    cyc(1, 0, OP_STOP, 0, "ps_run0", 0, 1, 0, 0, 1, 0);
    cyc(1, 0, OP_STOP, 0, "ps_run1", 1, 1, 0, 0, 1, 0);
    cyc(1, 1, OP_PAUSE, 0, "ps_pause", 2, 1, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, OP_STOP, 0, "ps_hold", 2, 1, 0, 0, 1, 0);
    cyc(1, 1, OP_PAUSE, 0, "ps_resume", 2, 1, 0, 0, 1, 0);
    cyc(1, 0, OP_STOP, 0, "ps_res2", 2, 1, 0, 0, 1, 0);
    cyc(1, 1, OP_STOP, 0, "ps_stop", 3, 1, 0, 0, 1, 0);
    cyc(1, 1, OP_PAUSE, 0, "idle_pause_ign", 0, 0, 0, 0, 1, 0);
    cyc(1, 1, OP_ONESHOT, 9, "rs_start", 0, 0, 0, 0, 1, 0);
    for (int k = 0; k <= 7; k++) cyc(1, 0, OP_STOP, 0, "rs_run", 4'(k), 1, 0, 0, 1, 0);
    cyc(0, 0, OP_STOP, 0, "rs_async", 0, 0, 0, 0, 1, 0);
    cyc(0, 0, OP_STOP, 0, "rs_held", 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, OP_STOP, 0, "rs_quiet", 0, 0, 0, 0, 1, 0);
    cyc(1, 1, OP_PERIODIC, 0, "p0_start", 0, 0, 0, 0, 1, 0);
    for (int j = 0; j < 300; j++)
      cyc(1, 1, OP_STOP, 0, "p0_run", 0, 1, 0, 1'(j > 0), 0, 8'(j > 255 ? 255 : j));
    cyc(0, 0, OP_STOP, 0, "p0_reset", 0, 0, 0, 0, 1, 0);
    cyc(1, 1, OP_PERIODIC, 1, "p1_start", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 520; i++)
      cyc(1, 0, OP_STOP, 0, "p1_run", 4'(i % 2), 1, 0, 1'(i > 0 && i % 2 == 0),
          1'(i % 2 == 0), 8'(i / 2 > 255 ? 255 : i / 2));
    cyc(1, 1, OP_ONESHOT, 2, "p1_restart", 0, 1, 0, 1, 1, 255);
    cyc(1, 0, OP_STOP, 0, "rst2_0", 0, 1, 0, 0, 1, 0);
    cyc(1, 0, OP_STOP, 0, "rst2_1", 1, 1, 0, 0, 1, 0);
    cyc(1, 0, OP_STOP, 0, "rst2_2", 2, 1, 0, 0, 0, 0);
    cyc(1, 1, OP_PAUSE, 0, "done_pause_ign", 2, 0, 1, 1, 1, 0);
    cyc(1, 1, OP_STOP, 0, "done_stop", 2, 0, 1, 0, 1, 0);
    cyc(1, 1, OP_ONESHOT, 15, "max_start", 0, 0, 0, 0, 1, 0);
    for (int k = 0; k <= 15; k++)
      cyc(1, 0, OP_STOP, 0, "max_run", 4'(k), 1, 0, 0, 1'(k != 15), 0);
    cyc(1, 0, OP_STOP, 0, "max_done", 15, 0, 1, 1, 1, 0);
    cyc(1, 0, OP_STOP, 0, "max_hold", 15, 0, 1, 0, 1, 0);
    @(negedge clk);
    #1;
    total++;
    if (count == 4'd15 && done && !busy) passed++;
    else $display("FAIL final_done count=%0d done=%0b busy=%0b", count, done, busy);
    total++;
    if (cmd_ready && !tc_pulse && wraps == 8'd0) passed++;
    else $display("FAIL final_flags ready=%0b tc=%0b wraps=%0d", cmd_ready, tc_pulse, wraps);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL queue_drain left=%0d", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    if (passed != total) $fatal(1);
    $finish;
  end
endmodule
